// File: rtl/md_result_collector.sv
// Serial-to-parallel sign-magnitude collector for the multiply/divide result stream.
// Optional divide rounding with a guard bit: define MD_ROUND_EN.
module md_result_collector #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic             sign_in,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             abort,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overflow
);

  localparam int MAG = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  logic [1:0]     state;
  logic [MAG-1:0] shreg;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  last_cnt;
  logic           div_q;
  logic           sign_q;
  logic [MAG-1:0] mag_final;
  logic           ovf_final;
  logic           accept;
  logic           done;
  logic           go;

  assign busy   = (state == COLLECT);
  assign accept = (state == COLLECT) && bit_valid && !abort;
  // abort outranks start; a start in HOLD only counts when the result is taken
  assign go     = start && !abort &&
                  ((state == IDLE) || ((state == HOLD) && result_ready));

`ifdef MD_ROUND_EN
  assign last_cnt = div_q ? CW'(MAG) : CW'(MAG - 1);
`else
  assign last_cnt = CW'(MAG - 1);
`endif

  assign done = accept && (cnt == last_cnt);

  always_comb begin
    mag_final = {bit_in, shreg[MAG-1:1]};
    ovf_final = 1'b0;
    if (div_q) begin
`ifdef MD_ROUND_EN
      // bit_in is the guard bit here; it rounds the magnitude but is not stored
      if (!bit_in) begin
        mag_final = shreg;
      end else if (&shreg) begin
        mag_final = shreg;
        ovf_final = 1'b1;
      end else begin
        mag_final = shreg + {{(MAG-1){1'b0}}, 1'b1};
      end
`else
      mag_final = {shreg[MAG-2:0], bit_in};
`endif
    end
  end

`ifdef MD_ROUND_EN
  logic ovf_q;
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      shreg        <= '0;
      cnt          <= '0;
      div_q        <= 1'b0;
      sign_q       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
`ifdef MD_ROUND_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state  <= COLLECT;
            div_q  <= op_div;
            sign_q <= sign_in;
            shreg  <= '0;
            cnt    <= '0;
          end
        end
        COLLECT: begin
          if (abort) begin
            state <= IDLE;
          end else if (accept) begin
            cnt <= cnt + CW'(1);
            if (div_q) shreg <= {shreg[MAG-2:0], bit_in};
            else       shreg <= {bit_in, shreg[MAG-1:1]};
            if (done) begin
              state        <= HOLD;
              result       <= {sign_q, mag_final};
              result_valid <= 1'b1;
`ifdef MD_ROUND_EN
              ovf_q        <= ovf_final;
`endif
            end
          end
        end
        HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            if (go) begin
              state  <= COLLECT;
              div_q  <= op_div;
              sign_q <= sign_in;
              shreg  <= '0;
              cnt    <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MD_ROUND_EN
  logic unused_ovf;
  assign unused_ovf = ovf_final;
`endif

endmodule

// File: tb/tb_md_result_collector.sv
// Directed self-checking bench for md_result_collector.
module tb_md_result_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op_div = 1'b0;
  logic        sign_in = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        abort = 1'b0;
  logic        result_ready = 1'b0;
  logic        busy;
  logic [25:0] result;
  logic        result_valid;
  logic        overflow;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef MD_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  md_result_collector #(.WIDTH(26)) dut (
    .clk(clk), .rst(rst), .start(start), .op_div(op_div), .sign_in(sign_in),
    .bit_in(bit_in), .bit_valid(bit_valid), .abort(abort), .busy(busy),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic div, input logic sgn);
    start = 1'b1; op_div = div; sign_in = sgn;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int gap);
    bit_valid = 1'b1; bit_in = b;
    tick();
    bit_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // n bits of v, multiply order (LSB-first) or divide order (MSB-first of 25)
  task automatic send_word(input logic [24:0] v, input logic div, input int n, input int gap);
    for (int i = 0; i < n; i++) send_bit(div ? v[24-i] : v[i], gap);
  endtask

  task automatic take_result();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("handshake_clears_valid", {31'd0, result_valid}, 32'd0);
  endtask

  initial begin
    logic [25:0] held;

    // reset state
    repeat (2) tick();
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_result", {6'd0, result}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);

    // reset in the middle of a collection
    do_start(1'b0, 1'b1);
    send_word(25'h1FFFFFF, 1'b0, 10, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, result_valid}, 32'd0);
    check("midrst_result", {6'd0, result}, 32'd0);
    check("midrst_ovf", {31'd0, overflow}, 32'd0);

    // multiply, negative, value 5 LSB-first
    do_start(1'b0, 1'b1);
    check("mul_busy_after_start", {31'd0, busy}, 32'd1);
    send_word(25'h0000005, 1'b0, 24, 0);
    check("mul_not_done_24", {31'd0, result_valid}, 32'd0);
    send_bit(1'b0, 0);
    check("mul_valid", {31'd0, result_valid}, 32'd1);
    check("mul_busy_done", {31'd0, busy}, 32'd0);
    check("mul_result", {6'd0, result}, 32'h2000005);
    check("mul_ovf", {31'd0, overflow}, 32'd0);
    take_result();
    check("mul_idle_busy", {31'd0, busy}, 32'd0);

    // divide, MSB-first with 3-cycle gaps
    do_start(1'b1, 1'b0);
    send_word(25'h1000000, 1'b1, 25, 3);
    if (ROUND) begin
      check("div_wait_guard", {31'd0, result_valid}, 32'd0);
      send_bit(1'b0, 0);
    end
    check("div_valid", {31'd0, result_valid}, 32'd1);
    check("div_result", {6'd0, result}, 32'h1000000);
    check("div_ovf", {31'd0, overflow}, 32'd0);
    take_result();

    // all-ones divide: saturates with rounding, plain otherwise
    do_start(1'b1, 1'b0);
    send_word(25'h1FFFFFF, 1'b1, 25, 0);
    if (ROUND) begin
      check("rnd_wait_guard", {31'd0, result_valid}, 32'd0);
      send_bit(1'b1, 0);
    end
    check("rnd_valid", {31'd0, result_valid}, 32'd1);
    check("rnd_result", {6'd0, result}, 32'h1FFFFFF);
    check("rnd_ovf", {31'd0, overflow}, {31'd0, ROUND});
    take_result();

    // abort with start in IDLE stays idle
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", {31'd0, busy}, 32'd0);
    tick();
    check("abort_start_still_idle", {31'd0, busy}, 32'd0);

    // abort after 12 bits keeps the earlier result
    do_start(1'b0, 1'b1);
    send_word(25'h0000ABC, 1'b0, 12, 0);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    abort = 1'b0; bit_valid = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, result_valid}, 32'd0);
    check("abort_result_kept", {6'd0, result}, 32'h1FFFFFF);
    check("abort_ovf_kept", {31'd0, overflow}, {31'd0, ROUND});

    // backpressure: result held, starts ignored
    do_start(1'b0, 1'b0);
    send_word(25'h0ABCDEF, 1'b0, 25, 0);
    check("bp_result", {6'd0, result}, 32'h0ABCDEF);
    held = result;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; op_div = 1'b1;
      tick();
      check("bp_valid_held", {31'd0, result_valid}, 32'd1);
      check("bp_result_stable", {6'd0, result}, {6'd0, held});
      check("bp_start_ignored", {31'd0, busy}, 32'd0);
    end
    start = 1'b0;

    // handshake with start in the same cycle
    result_ready = 1'b1; start = 1'b1; op_div = 1'b0; sign_in = 1'b1;
    tick();
    result_ready = 1'b0; start = 1'b0;
    check("b2b_valid", {31'd0, result_valid}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    send_word(25'h1555555, 1'b0, 25, 0);
    check("b2b_valid_done", {31'd0, result_valid}, 32'd1);
    check("b2b_result", {6'd0, result}, 32'h3555555);
    check("b2b_ovf", {31'd0, overflow}, 32'd0);
    take_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
